// File: rtl/countdown_timer_module.sv
// BCD HH:MM:SS.cc countdown timer with built-in run/pause, expiry and preset reload.
// Optional: define COUNTDOWN_AUTO_RELOAD_EN to reload the preset and keep running at zero.
module countdown_timer_module #(
    parameter bit         RUN_ON_LOAD = 1'b0,
    parameter logic [3:0] MAX_HR_TENS = 4'd9
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        tick_i,
    input  logic        run_pause_button_i,
    input  logic        timer_reset_i,
    input  logic        load_i,
    input  logic [23:0] preset_i,
    output logic [3:0]  centisec_o,
    output logic [3:0]  decisec_o,
    output logic [3:0]  sec_o,
    output logic [3:0]  decasec_o,
    output logic [3:0]  min_o,
    output logic [3:0]  decamin_o,
    output logic [3:0]  hr_o,
    output logic [3:0]  decahr_o,
    output logic        running_o,
    output logic        expired_o
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PAUSE   = 2'd1;
    localparam logic [1:0] ST_RUN     = 2'd2;
    localparam logic [1:0] ST_EXPIRED = 2'd3;

    // Per-digit limits, packed in the same order as the count register.
    localparam logic [31:0] DIGIT_MAX = {
        MAX_HR_TENS, 4'd9, 4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9
    };

    logic [1:0]  state_q, state_d;
    logic [31:0] count_q, count_d;
    logic [23:0] preset_q, preset_d;
    logic [23:0] preset_clean;
    logic [31:0] count_dec;
    logic        count_zero;
    logic        dec_zero;
    logic        preset_zero;
    logic        clean_zero;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic        pulse_q, pulse_d;
`endif

    function automatic logic [23:0] sanitize(input logic [23:0] raw);
        logic [23:0] res;
        res = raw;
        for (int i = 0; i < 6; i++) begin
            if (raw[4*i +: 4] > DIGIT_MAX[4*i+8 +: 4]) begin
                res[4*i +: 4] = DIGIT_MAX[4*i+8 +: 4];
            end
        end
        return res;
    endfunction

    // Ripple borrow across all eight digits in one cycle.
    function automatic logic [31:0] decrement(input logic [31:0] cnt);
        logic [31:0] res;
        logic        borrow;
        res    = cnt;
        borrow = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (borrow) begin
                if (cnt[4*i +: 4] == 4'd0) begin
                    res[4*i +: 4] = DIGIT_MAX[4*i +: 4];
                end else begin
                    res[4*i +: 4] = cnt[4*i +: 4] - 4'd1;
                    borrow        = 1'b0;
                end
            end
        end
        return res;
    endfunction

    assign preset_clean = sanitize(preset_i);
    assign count_dec    = decrement(count_q);
    assign count_zero   = (count_q == 32'd0);
    assign dec_zero     = (count_dec == 32'd0);
    assign preset_zero  = (preset_q == 24'd0);
    assign clean_zero   = (preset_clean == 24'd0);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        preset_d = preset_q;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        pulse_d  = 1'b0;
`endif
        if (timer_reset_i) begin
            count_d = {preset_q, 8'h00};
            state_d = preset_zero ? ST_IDLE : ST_PAUSE;
        end else if (load_i && (state_q != ST_RUN)) begin
            preset_d = preset_clean;
            count_d  = {preset_clean, 8'h00};
            if (clean_zero) begin
                state_d = ST_IDLE;
            end else begin
                state_d = RUN_ON_LOAD ? ST_RUN : ST_PAUSE;
            end
        end else if (run_pause_button_i) begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_PAUSE: begin
                    if (!count_zero) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    state_d = ST_PAUSE;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    if (count_zero) begin
                        count_d = {preset_q, 8'h00};
                    end
`endif
                end
                ST_EXPIRED: begin
                    state_d = ST_IDLE;
                    count_d = 32'd0;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if (state_q == ST_RUN) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            // Zero is shown for one cycle, then the preset is reloaded.
            if (count_zero) begin
                count_d = {preset_q, 8'h00};
                if (preset_zero) begin
                    state_d = ST_EXPIRED;
                end
            end else if (tick_i) begin
                count_d = count_dec;
                pulse_d = dec_zero;
            end
`else
            if (tick_i) begin
                count_d = count_dec;
                if (dec_zero) begin
                    state_d = ST_EXPIRED;
                end
            end
`endif
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            count_q  <= 32'd0;
            preset_q <= 24'd0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            preset_q <= preset_d;
        end
    end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= pulse_d;
        end
    end

    assign expired_o = (state_q == ST_EXPIRED) | pulse_q;
`else
    assign expired_o = (state_q == ST_EXPIRED);
`endif

    assign running_o = (state_q == ST_RUN);

    assign {decahr_o, hr_o, decamin_o, min_o,
            decasec_o, sec_o, decisec_o, centisec_o} = count_q;

endmodule

// File: tb/tb_countdown_timer_module.sv
// Scoreboard bench for countdown_timer_module: centisecond-integer reference model,
// directed scenarios followed by randomized stimulus.
module tb_countdown_timer_module;

    localparam bit         RUN_ON_LOAD = 1'b0;
    localparam logic [3:0] MAX_HR_TENS = 4'd9;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        tick_i = 1'b0;
    logic        run_pause_button_i = 1'b0;
    logic        timer_reset_i = 1'b0;
    logic        load_i = 1'b0;
    logic [23:0] preset_i = 24'h0;
    logic [3:0]  centisec_o, decisec_o, sec_o, decasec_o;
    logic [3:0]  min_o, decamin_o, hr_o, decahr_o;
    logic        running_o, expired_o;

    countdown_timer_module #(
        .RUN_ON_LOAD(RUN_ON_LOAD),
        .MAX_HR_TENS(MAX_HR_TENS)
    ) dut (
        .clk_i(clk_i),
        .reset_i(reset_i),
        .tick_i(tick_i),
        .run_pause_button_i(run_pause_button_i),
        .timer_reset_i(timer_reset_i),
        .load_i(load_i),
        .preset_i(preset_i),
        .centisec_o(centisec_o),
        .decisec_o(decisec_o),
        .sec_o(sec_o),
        .decasec_o(decasec_o),
        .min_o(min_o),
        .decamin_o(decamin_o),
        .hr_o(hr_o),
        .decahr_o(decahr_o),
        .running_o(running_o),
        .expired_o(expired_o)
    );

    always #5 clk_i = ~clk_i;

    typedef enum {M_IDLE, M_PAUSE, M_RUN, M_EXP} mstate_e;

    // Model keeps the count as plain centiseconds.
    int      m_cnt;
    int      m_preset;
    mstate_e m_state;
    bit      m_pulse;

    logic [33:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    function automatic logic [33:0] actual();
        return {decahr_o, hr_o, decamin_o, min_o, decasec_o, sec_o,
                decisec_o, centisec_o, running_o, expired_o};
    endfunction

    function automatic logic [31:0] to_digits(input int c);
        int h, m, s;
        h = c / 360000;
        m = (c / 6000) % 60;
        s = (c / 100) % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
                4'(s / 10), 4'(s % 10), 4'((c / 10) % 10), 4'(c % 10)};
    endfunction

    function automatic int clip(input logic [3:0] d, input int lim);
        return (int'(d) > lim) ? lim : int'(d);
    endfunction

    function automatic int preset_cs(input logic [23:0] p);
        int hh, mm, ss;
        hh = 10 * clip(p[23:20], int'(MAX_HR_TENS)) + clip(p[19:16], 9);
        mm = 10 * clip(p[15:12], 5) + clip(p[11:8], 9);
        ss = 10 * clip(p[7:4], 5) + clip(p[3:0], 9);
        return ((hh * 60 + mm) * 60 + ss) * 100;
    endfunction

    task automatic check(input string name, input logic [33:0] got,
                         input logic [33:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got digits=%h run=%b exp=%b, want digits=%h run=%b exp=%b",
                     name, got[33:2], got[1], got[0], want[33:2], want[1], want[0]);
        end
    endtask

    task automatic model_reset();
        m_cnt    = 0;
        m_preset = 0;
        m_state  = M_IDLE;
        m_pulse  = 1'b0;
    endtask

    task automatic model_step(input logic tr, input logic ld, input logic bp,
                              input logic tk, input logic [23:0] p);
        m_pulse = 1'b0;
        if (tr) begin
            m_cnt   = m_preset;
            m_state = (m_preset == 0) ? M_IDLE : M_PAUSE;
        end else if (ld && m_state != M_RUN) begin
            m_preset = preset_cs(p);
            m_cnt    = m_preset;
            if (m_preset == 0) m_state = M_IDLE;
            else m_state = RUN_ON_LOAD ? M_RUN : M_PAUSE;
        end else if (bp) begin
            if (m_state == M_PAUSE && m_cnt != 0) m_state = M_RUN;
            else if (m_state == M_RUN) begin
                m_state = M_PAUSE;
                if (AUTO && m_cnt == 0) m_cnt = m_preset;
            end else if (m_state == M_EXP) begin
                m_state = M_IDLE;
                m_cnt   = 0;
            end
        end else if (m_state == M_RUN) begin
            if (AUTO && m_cnt == 0) begin
                m_cnt = m_preset;
                if (m_preset == 0) m_state = M_EXP;
            end else if (tk) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    if (AUTO) m_pulse = 1'b1;
                    else m_state = M_EXP;
                end
            end
        end
        exp_q.push_back({to_digits(m_cnt), m_state == M_RUN,
                         (m_state == M_EXP) || m_pulse});
    endtask

    task automatic step(input logic tr, input logic ld, input logic bp,
                        input logic tk, input logic [23:0] p);
        @(negedge clk_i);
        reset_i            = 1'b0;
        timer_reset_i      = tr;
        load_i             = ld;
        run_pause_button_i = bp;
        tick_i             = tk;
        preset_i           = p;
        model_step(tr, ld, bp, tk, p);
    endtask

    task automatic async_reset_check(input string name);
        @(posedge clk_i);
        #3;
        reset_i            = 1'b1;
        timer_reset_i      = 1'b0;
        load_i             = 1'b0;
        run_pause_button_i = 1'b0;
        tick_i             = 1'b0;
        #1;
        check(name, actual(), 34'd0);
        model_reset();
    endtask

    function automatic logic [23:0] rand_preset();
        case ($urandom % 4)
            0: return 24'($urandom);
            1: return 24'($urandom % 4);
            2: return {16'h0, 8'($urandom)};
            default: return 24'h0;
        endcase
    endfunction

    initial begin
        logic [33:0] e;
        forever begin
            @(posedge clk_i);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cycle", actual(), e);
            end
        end
    end

    initial begin
        #1 reset_i = 1'b1;
        #1 check("reset", actual(), 34'd0);
        model_reset();

        step(0, 1, 0, 0, 24'h000105);
        step(0, 0, 1, 0, 24'h0);
        repeat (6505) step(0, 0, 0, 1, 24'h0);

        step(0, 0, 1, 0, 24'h0);
        step(0, 1, 0, 0, 24'h995999);
        step(0, 0, 1, 0, 24'h0);
        step(0, 0, 0, 1, 24'h0);
        step(0, 0, 1, 1, 24'h0);
        step(0, 0, 0, 1, 24'h0);

        step(0, 1, 0, 0, 24'hF7A9C9);
        step(0, 0, 1, 0, 24'h0);
        step(0, 0, 0, 1, 24'h0);
        step(0, 1, 0, 1, 24'h000300);
        repeat (3) step(0, 0, 0, 1, 24'h0);

        step(0, 0, 1, 0, 24'h0);
        step(0, 1, 0, 0, 24'h000001);
        step(0, 0, 1, 0, 24'h0);
        repeat (100) step(0, 0, 0, 1, 24'h0);
        repeat (3) step(0, 0, 0, 0, 24'h0);
        step(0, 0, 1, 0, 24'h0);
        step(0, 0, 1, 0, 24'h0);
        step(1, 1, 0, 0, 24'h000200);

        step(0, 0, 1, 0, 24'h0);
        repeat (20) step(0, 0, 0, 1, 24'h0);
        async_reset_check("async_reset");
        step(1, 0, 0, 0, 24'h0);
        step(0, 0, 1, 1, 24'h0);

        for (int i = 0; i < 6000; i++) begin
            if (($urandom % 700) == 0) begin
                async_reset_check("rand_async_reset");
            end
            step(($urandom % 120) == 0, ($urandom % 60) == 0,
                 ($urandom % 25) == 0, ($urandom % 2) == 0, rand_preset());
        end

        @(negedge clk_i);
        tick_i             = 1'b0;
        load_i             = 1'b0;
        run_pause_button_i = 1'b0;
        timer_reset_i      = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            @(posedge clk_i);
            #2;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
